// File: rtl/psk_pkg.sv
// Shared state encoding and width helper for the PSK symbol serializer.
package psk_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psk_bit_timer.sv
// Clock-within-bit and bit-within-symbol counters with framing flags.
module psk_bit_timer
    import psk_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 4,
    parameter int BITS_PER_SYMBOL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_bit_end,
    output logic o_symbol_end,
    output logic o_bit_zero,
    output logic o_first_half
);

    localparam int CLK_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = cnt_width(BITS_PER_SYMBOL);
    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] CLK_HALF = CLK_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_SYMBOL - 1);

    logic [CLK_W-1:0] r_clk_cnt;
    logic [BIT_W-1:0] r_bit_cnt;

    assign o_bit_end    = (r_clk_cnt == CLK_LAST);
    assign o_symbol_end = o_bit_end && (r_bit_cnt == BIT_LAST);
    assign o_bit_zero   = (r_bit_cnt == '0);
    assign o_first_half = (r_clk_cnt < CLK_HALF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (i_en) begin
            if (o_bit_end) begin
                r_clk_cnt <= '0;
                r_bit_cnt <= o_symbol_end ? '0 : r_bit_cnt + 1'b1;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/psk_symbol_serializer.sv
// PSK symbol serializer: pops samples from a show-ahead FIFO and shifts them onto pwm
// with repetition, gap-free prefetch, bclk/nsync framing and underrun reporting.
module psk_symbol_serializer
    import psk_pkg::*;
#(
    parameter int SAMPLE_W        = 8,
    parameter int BITS_PER_SYMBOL = 4,
    parameter int CLKS_PER_BIT    = 4,
    parameter int REPEAT_W        = 8,
    parameter bit MSB_FIRST       = 1'b0,
    parameter bit IDLE_LEVEL      = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                empty,
    output logic                read,
    output logic                pwm,
    output logic                bclk,
    output logic                nsync,
    output logic                symb_strobe,
    output logic                underrun,
    output logic                busy
);

    state_t              r_state, w_state_d;
    logic [SAMPLE_W-1:0] r_shift, w_shift_d;
    logic [SAMPLE_W-1:0] r_active, w_active_d;
    logic [SAMPLE_W-1:0] r_next, w_next_d;
    logic                r_next_valid, w_next_valid_d;
    logic [REPEAT_W-1:0] r_rep_cnt, w_rep_cnt_d;
    logic [REPEAT_W-1:0] r_rep_last, w_rep_last_d;
    logic                r_read, w_read_d;
    logic                r_strobe, w_strobe_d;
    logic                r_underrun, w_underrun_d;

    logic                w_run;
    logic                w_bit_end;
    logic                w_symbol_end;
    logic                w_bit_zero;
    logic                w_first_half;
    logic                w_can_read;
    logic                w_last_rep;
    logic                w_boundary;
    logic [REPEAT_W-1:0] w_rep_last_in;
    logic [SAMPLE_W-1:0] w_shifted;
    logic                w_serial_bit;

    assign w_run = (r_state == ST_RUN);

    psk_bit_timer #(
        .CLKS_PER_BIT   (CLKS_PER_BIT),
        .BITS_PER_SYMBOL(BITS_PER_SYMBOL)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .i_en        (enable && w_run),
        .o_bit_end   (w_bit_end),
        .o_symbol_end(w_symbol_end),
        .o_bit_zero  (w_bit_zero),
        .o_first_half(w_first_half)
    );

    // A repeat count of 0 plays once, so the terminal index saturates at 0.
    assign w_rep_last_in = (repeat_cnt == '0) ? '0 : repeat_cnt - 1'b1;
    assign w_can_read    = !empty && !r_read;
    assign w_last_rep    = (r_rep_cnt == r_rep_last);
    assign w_boundary    = w_run && w_symbol_end && w_last_rep;
    assign w_shifted     = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
    assign w_serial_bit  = MSB_FIRST ? r_shift[SAMPLE_W-1] : r_shift[0];

    always_comb begin
        w_state_d      = r_state;
        w_shift_d      = r_shift;
        w_active_d     = r_active;
        w_next_d       = r_next;
        w_next_valid_d = r_next_valid;
        w_rep_cnt_d    = r_rep_cnt;
        w_rep_last_d   = r_rep_last;
        w_read_d       = 1'b0;
        w_strobe_d     = 1'b0;
        w_underrun_d   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_can_read) begin
                    w_state_d    = ST_RUN;
                    w_shift_d    = sample;
                    w_active_d   = sample;
                    w_rep_cnt_d  = '0;
                    w_rep_last_d = w_rep_last_in;
                    w_read_d     = 1'b1;
                    w_strobe_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_bit_end && !w_symbol_end) begin
                    w_shift_d = w_shifted;
                end else if (w_symbol_end && !w_last_rep) begin
                    w_rep_cnt_d = r_rep_cnt + 1'b1;
                    w_shift_d   = r_active;
                end else if (w_boundary) begin
                    w_rep_cnt_d  = '0;
                    w_rep_last_d = w_rep_last_in;
                    if (r_next_valid) begin
                        w_shift_d      = r_next;
                        w_active_d     = r_next;
                        w_next_valid_d = 1'b0;
                        w_strobe_d     = 1'b1;
                    end else if (w_can_read) begin
                        w_shift_d  = sample;
                        w_active_d = sample;
                        w_read_d   = 1'b1;
                        w_strobe_d = 1'b1;
                    end else begin
                        w_underrun_d = 1'b1;
                        w_state_d    = ST_IDLE;
                    end
                end

                if (!w_boundary && !r_next_valid && w_can_read) begin
                    w_next_d       = sample;
                    w_next_valid_d = 1'b1;
                    w_read_d       = 1'b1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_active     <= '0;
            r_next       <= '0;
            r_next_valid <= 1'b0;
            r_rep_cnt    <= '0;
            r_rep_last   <= '0;
            r_read       <= 1'b0;
            r_strobe     <= 1'b0;
            r_underrun   <= 1'b0;
        end else if (enable) begin
            r_state      <= w_state_d;
            r_shift      <= w_shift_d;
            r_active     <= w_active_d;
            r_next       <= w_next_d;
            r_next_valid <= w_next_valid_d;
            r_rep_cnt    <= w_rep_cnt_d;
            r_rep_last   <= w_rep_last_d;
            r_read       <= w_read_d;
            r_strobe     <= w_strobe_d;
            r_underrun   <= w_underrun_d;
        end
    end

    // NOTE: pulse registers freeze with everything else and are masked at the port,
    // so a pulse pending across a freeze is presented exactly once after resuming.
    assign read        = r_read && enable;
    assign symb_strobe = r_strobe && enable;
    assign underrun    = r_underrun && enable;

    assign busy  = w_run;
    assign pwm   = w_run ? w_serial_bit : IDLE_LEVEL;
    assign bclk  = w_run && w_first_half;
    assign nsync = !(w_run && w_bit_zero);

endmodule

// File: tb/tb_psk_symbol_serializer.sv
// Self-checking bench for psk_symbol_serializer: LSB-first and MSB-first instances fed by FIFO models.
module tb_psk_symbol_serializer;

    localparam int CPB = 4;
    localparam int BPS = 4;

    typedef struct packed {
        logic pwm;
        logic bclk;
        logic nsync;
        logic busy;
        logic strobe;
        logic underrun;
        logic rd_emp;
    } obs_t;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       enable     = 1'b0;
    logic [7:0] repeat_cnt = 8'd1;

    logic [7:0] sample_a, sample_b;
    logic       empty_a, empty_b;
    logic       read_a, pwm_a, bclk_a, nsync_a, strobe_a, underrun_a, busy_a;
    logic       read_b, pwm_b, bclk_b, nsync_b, strobe_b, underrun_b, busy_b;

    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];
    int head_a = 0, tail_a = 0, head_b = 0, tail_b = 0;
    int reads_a = 0, reads_b = 0;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    psk_symbol_serializer dut_a (
        .clk(clk), .rst(rst), .enable(enable), .repeat_cnt(repeat_cnt),
        .sample(sample_a), .empty(empty_a), .read(read_a), .pwm(pwm_a),
        .bclk(bclk_a), .nsync(nsync_a), .symb_strobe(strobe_a),
        .underrun(underrun_a), .busy(busy_a)
    );

    psk_symbol_serializer #(.MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .repeat_cnt(repeat_cnt),
        .sample(sample_b), .empty(empty_b), .read(read_b), .pwm(pwm_b),
        .bclk(bclk_b), .nsync(nsync_b), .symb_strobe(strobe_b),
        .underrun(underrun_b), .busy(busy_b)
    );

    // Show-ahead FIFO models; a visible read pops the head before the next edge.
    assign empty_a  = (head_a == tail_a);
    assign empty_b  = (head_b == tail_b);
    assign sample_a = mem_a[head_a % 64];
    assign sample_b = mem_b[head_b % 64];

    always @(negedge clk) begin
        if (read_a && (head_a != tail_a)) begin
            head_a  <= head_a + 1;
            reads_a <= reads_a + 1;
        end
        if (read_b && (head_b != tail_b)) begin
            head_b  <= head_b + 1;
            reads_b <= reads_b + 1;
        end
    end

    task automatic push(input bit sel_b, input logic [7:0] v);
        if (sel_b) begin
            mem_b[tail_b % 64] = v;
            tail_b++;
        end else begin
            mem_a[tail_a % 64] = v;
            tail_a++;
        end
    endtask

    function automatic obs_t idle_obs(input logic und);
        obs_t e;
        e          = '0;
        e.nsync    = 1'b1;
        e.underrun = und;
        return e;
    endfunction

    // Reference: each repetition plays BPS bits of the sample for CPB clocks each.
    task automatic exp_symbol(input logic [7:0] s, input int reps, input bit msb);
        obs_t e;
        int   n_rep;
        n_rep = (reps == 0) ? 1 : reps;
        for (int r = 0; r < n_rep; r++) begin
            for (int b = 0; b < BPS; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    e          = '0;
                    e.pwm      = msb ? s[7 - b] : s[b];
                    e.bclk     = (c < CPB / 2);
                    e.nsync    = (b != 0);
                    e.busy     = 1'b1;
                    e.strobe   = (r == 0) && (b == 0) && (c == 0);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic step_obs(input bit sel_b, output obs_t o, output logic rd);
        @(negedge clk);
        if (sel_b) begin
            o = {pwm_b, bclk_b, nsync_b, busy_b, strobe_b, underrun_b, read_b & empty_b};
            rd = read_b;
        end else begin
            o = {pwm_a, bclk_a, nsync_a, busy_a, strobe_a, underrun_a, read_a & empty_a};
            rd = read_a;
        end
    endtask

    task automatic test_reset();
        obs_t o, e;
        logic rd;
        e = idle_obs(1'b0);
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 2; s++) begin
                step_obs(s[0], o, rd);
                n_checks++;
                if (o !== e || rd !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset[%0d] dut%0d: got %b read=%b required %b read=0", i, s, o, rd, e);
                end
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step_obs(1'b0, o, rd);
            n_checks++;
            if (o !== e || rd !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_empty[%0d]: got %b read=%b required %b read=0", i, o, rd, e);
            end
        end
    endtask

    task automatic test_single();
        obs_t o, e;
        logic rd;
        int   i, r0;
        r0 = reads_a;
        repeat_cnt = 8'd1;
        push(1'b0, 8'hA5);
        exp_symbol(8'hA5, 1, 1'b0);
        exp_q.push_back(idle_obs(1'b1));
        exp_q.push_back(idle_obs(1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step_obs(1'b0, o, rd);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single[%0d]: got %b required %b", i, o, e);
            end
            i++;
        end
        n_checks++;
        if (reads_a - r0 != 1) begin
            n_fail++;
            $display("FAIL single_reads: got %0d required 1", reads_a - r0);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic rd;
        int   i, r0;
        r0 = reads_a;
        repeat_cnt = 8'd2;
        push(1'b0, 8'hA5);
        push(1'b0, 8'h3C);
        exp_symbol(8'hA5, 2, 1'b0);
        exp_symbol(8'h3C, 2, 1'b0);
        exp_q.push_back(idle_obs(1'b1));
        exp_q.push_back(idle_obs(1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step_obs(1'b0, o, rd);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %b required %b", i, o, e);
            end
            i++;
        end
        n_checks++;
        if (reads_a - r0 != 2) begin
            n_fail++;
            $display("FAIL back_to_back_reads: got %0d required 2", reads_a - r0);
        end
    endtask

    task automatic test_msb_first();
        obs_t o, e;
        logic rd;
        int   i;
        repeat_cnt = 8'd0;
        push(1'b1, 8'hA5);
        exp_symbol(8'hA5, 0, 1'b1);
        exp_q.push_back(idle_obs(1'b1));
        exp_q.push_back(idle_obs(1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step_obs(1'b1, o, rd);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL msb_first[%0d]: got %b required %b", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_random();
        obs_t       o, e;
        logic       rd;
        logic [7:0] s;
        int         n, reps, i, r0;
        bit         sel;
        for (int it = 0; it < 4; it++) begin
            sel  = it[0];
            n    = $urandom_range(2, 4);
            reps = $urandom_range(0, 3);
            r0   = sel ? reads_b : reads_a;
            repeat_cnt = 8'(reps);
            for (int k = 0; k < n; k++) begin
                s = 8'($urandom);
                push(sel, s);
                exp_symbol(s, reps, sel);
            end
            exp_q.push_back(idle_obs(1'b1));
            exp_q.push_back(idle_obs(1'b0));
            i = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                step_obs(sel, o, rd);
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL random%0d[%0d]: got %b required %b", it, i, o, e);
                end
                i++;
            end
            n_checks++;
            if ((sel ? reads_b : reads_a) - r0 != n) begin
                n_fail++;
                $display("FAIL random%0d_reads: got %0d required %0d", it,
                         (sel ? reads_b : reads_a) - r0, n);
            end
        end
    endtask

    task automatic test_enable_freeze();
        obs_t       o, e;
        logic       rd;
        logic [7:0] s;
        int         i;
        s = 8'($urandom);
        repeat_cnt = 8'd1;
        push(1'b0, s);
        exp_symbol(s, 1, 1'b0);
        exp_q.push_back(idle_obs(1'b1));
        exp_q.push_back(idle_obs(1'b0));
        for (i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            step_obs(1'b0, o, rd);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL freeze_pre[%0d]: got %b required %b", i, o, e);
            end
        end
        enable     = 1'b0;
        e.strobe   = 1'b0;
        e.underrun = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step_obs(1'b0, o, rd);
            n_checks++;
            if (o !== e || rd !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze_hold[%0d]: got %b read=%b required %b read=0", k, o, rd, e);
            end
        end
        enable = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step_obs(1'b0, o, rd);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL freeze_post[%0d]: got %b required %b", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_late_prefetch();
        obs_t       o, e;
        logic       rd;
        logic [7:0] s1, s2;
        int         i, r0;
        r0 = reads_a;
        s1 = 8'($urandom);
        s2 = 8'($urandom);
        repeat_cnt = 8'd1;
        push(1'b0, s1);
        exp_symbol(s1, 1, 1'b0);
        exp_symbol(s2, 1, 1'b0);
        exp_q.push_back(idle_obs(1'b1));
        exp_q.push_back(idle_obs(1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            if (i == 5) push(1'b0, s2);
            e = exp_q.pop_front();
            step_obs(1'b0, o, rd);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL late_prefetch[%0d]: got %b required %b", i, o, e);
            end
            i++;
        end
        n_checks++;
        if (reads_a - r0 != 2) begin
            n_fail++;
            $display("FAIL late_prefetch_reads: got %0d required 2", reads_a - r0);
        end
    endtask

    task automatic test_reset_mid();
        obs_t       o, e;
        logic       rd;
        logic [7:0] s3;
        int         i;
        repeat_cnt = 8'd2;
        push(1'b0, 8'h5A);
        push(1'b0, 8'hC3);
        exp_symbol(8'h5A, 2, 1'b0);
        for (i = 0; i < 20; i++) begin
            e = exp_q.pop_front();
            step_obs(1'b0, o, rd);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_pre[%0d]: got %b required %b", i, o, e);
            end
        end
        exp_q.delete();
        rst = 1'b1;
        e   = idle_obs(1'b0);
        for (int k = 0; k < 2; k++) begin
            step_obs(1'b0, o, rd);
            n_checks++;
            if (o !== e || rd !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_hold[%0d]: got %b read=%b required %b read=0", k, o, rd, e);
            end
        end
        s3 = 8'($urandom);
        push(1'b0, s3);
        rst = 1'b0;
        exp_symbol(s3, 2, 1'b0);
        exp_q.push_back(idle_obs(1'b1));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step_obs(1'b0, o, rd);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_restart[%0d]: got %b required %b", i, o, e);
            end
            i++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        repeat_cnt = 8'd1;
        test_reset();
        test_single();
        test_back_to_back();
        test_msb_first();
        test_random();
        test_enable_freeze();
        test_late_prefetch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
